// File: rtl/move_sequencer.sv
// Per-axis move sequencer: turns absolute-position and homing commands into go/steps for one
// moveForward/moveBackward driver pair. Define MOVE_SEQ_SETTLE_EN to add a post-move SETTLE wait.
`ifdef MOVE_SEQ_SETTLE_EN
`ifndef MOVE_SEQ_SPEED
`define MOVE_SEQ_SPEED 4
`endif
`endif

module move_sequencer #(
    parameter int POS_W      = 12,
    parameter int HOME_STEPS = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_home,
    input  logic [POS_W-1:0] cmd_target,
    output logic             cmd_ready,
    output logic             go_fwd,
    output logic             go_bwd,
    output logic [POS_W-1:0] steps,
    output logic [3:0]       old_state,
    input  logic [3:0]       fwd_state,
    input  logic [3:0]       bwd_state,
    input  logic             fwd_done,
    input  logic             bwd_done,
    input  logic             boundary,
    output logic [POS_W-1:0] position,
    output logic             homed,
    output logic             error,
    output logic             busy
);

    localparam logic [POS_W-1:0] HOME_CNT = POS_W'(HOME_STEPS);
    localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};
`ifdef MOVE_SEQ_SETTLE_EN
    localparam int SETTLE_CYCLES = `MOVE_SEQ_SPEED;
`endif

    typedef enum logic [2:0] {IDLE, RUN, CAPTURE, RELEASE, SETTLE} state_t;

    state_t           state_reg;
    logic             dir_fwd_reg;
    logic             home_reg;
    logic             go_fwd_reg;
    logic             go_bwd_reg;
    logic [POS_W-1:0] steps_reg;
    logic [3:0]       old_state_reg;
    logic [POS_W-1:0] position_reg;
    logic             homed_reg;
    logic             error_reg;
    logic             busy_reg;
    logic             cmd_ready_reg;
    logic [3:0]       prev_reg;
    logic             base_valid_reg;
`ifdef MOVE_SEQ_SETTLE_EN
    int               settle_cnt_reg;
`endif

    logic [3:0] sel_state;
    logic       sel_done;
    logic       step_seen;

    // Only the driver we released is watched; the other one's state and done are don't-cares.
    assign sel_state = dir_fwd_reg ? fwd_state : bwd_state;
    assign sel_done  = dir_fwd_reg ? fwd_done  : bwd_done;
    assign step_seen = base_valid_reg && (sel_state != prev_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            dir_fwd_reg    <= 1'b0;
            home_reg       <= 1'b0;
            go_fwd_reg     <= 1'b0;
            go_bwd_reg     <= 1'b0;
            steps_reg      <= '0;
            old_state_reg  <= 4'b1100;
            position_reg   <= '0;
            homed_reg      <= 1'b0;
            error_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            cmd_ready_reg  <= 1'b1;
            prev_reg       <= 4'b0000;
            base_valid_reg <= 1'b0;
`ifdef MOVE_SEQ_SETTLE_EN
            settle_cnt_reg <= 0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        home_reg       <= cmd_home;
                        busy_reg       <= 1'b1;
                        cmd_ready_reg  <= 1'b0;
                        base_valid_reg <= 1'b0;
                        if (cmd_home) begin
                            steps_reg   <= HOME_CNT;
                            dir_fwd_reg <= 1'b0;
                            go_bwd_reg  <= 1'b1;
                            state_reg   <= RUN;
                        end else if (cmd_target > position_reg) begin
                            steps_reg   <= cmd_target - position_reg;
                            dir_fwd_reg <= 1'b1;
                            go_fwd_reg  <= 1'b1;
                            state_reg   <= RUN;
                        end else if (cmd_target < position_reg) begin
                            steps_reg   <= position_reg - cmd_target;
                            dir_fwd_reg <= 1'b0;
                            go_bwd_reg  <= 1'b1;
                            state_reg   <= RUN;
                        end else begin
                            state_reg   <= RELEASE;
                        end
                    end
                end
                RUN: begin
                    // First sample after go rises is only a baseline; later changes are steps.
                    base_valid_reg <= 1'b1;
                    prev_reg       <= sel_state;
                    if (step_seen) begin
                        if (dir_fwd_reg) begin
                            if (position_reg == POS_MAX) error_reg <= 1'b1;
                            else position_reg <= position_reg + 1'b1;
                        end else begin
                            if (position_reg == '0) error_reg <= 1'b1;
                            else position_reg <= position_reg - 1'b1;
                        end
                    end
                    if (sel_done) begin
                        go_fwd_reg <= 1'b0;
                        go_bwd_reg <= 1'b0;
                        state_reg  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    old_state_reg <= sel_state;
                    if (home_reg) begin
                        if (boundary) begin
                            position_reg <= '0;
                            homed_reg    <= 1'b1;
                            error_reg    <= 1'b0;
                        end else begin
                            homed_reg    <= 1'b0;
                            error_reg    <= 1'b1;
                        end
                    end else if (boundary) begin
                        homed_reg <= 1'b0;
                        error_reg <= 1'b1;
                    end else if (!homed_reg) begin
                        error_reg <= 1'b1;
                    end
                    state_reg <= RELEASE;
                end
                RELEASE: begin
`ifdef MOVE_SEQ_SETTLE_EN
                    settle_cnt_reg <= 0;
                    state_reg      <= SETTLE;
`else
                    busy_reg       <= 1'b0;
                    cmd_ready_reg  <= 1'b1;
                    state_reg      <= IDLE;
`endif
                end
`ifdef MOVE_SEQ_SETTLE_EN
                SETTLE: begin
                    if (settle_cnt_reg + 1 >= SETTLE_CYCLES) begin
                        busy_reg      <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign go_fwd    = go_fwd_reg;
    assign go_bwd    = go_bwd_reg;
    assign steps     = steps_reg;
    assign old_state = old_state_reg;
    assign position  = position_reg;
    assign homed     = homed_reg;
    assign error     = error_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: behavioural stepper drivers, a directed command table, a mid-move
// reset sequence and random commands checked against an arithmetic position/flag model.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_home;
    logic [11:0] cmd_target;
    logic        cmd_ready;
    logic        go_fwd;
    logic        go_bwd;
    logic [11:0] steps;
    logic [3:0]  old_state;
    logic [3:0]  fwd_state;
    logic [3:0]  bwd_state;
    logic        fwd_done;
    logic        bwd_done;
    logic        boundary;
    logic [11:0] position;
    logic        homed;
    logic        error;
    logic        busy;

    always #5 clk = ~clk;

    move_sequencer #(.POS_W(12), .HOME_STEPS(4095)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_home(cmd_home), .cmd_target(cmd_target), .cmd_ready(cmd_ready),
        .go_fwd(go_fwd), .go_bwd(go_bwd), .steps(steps), .old_state(old_state),
        .fwd_state(fwd_state), .bwd_state(bwd_state), .fwd_done(fwd_done), .bwd_done(bwd_done),
        .boundary(boundary), .position(position), .homed(homed), .error(error), .busy(busy)
    );

    // Behavioural drivers: load old_state while go is low, step one coil pattern per cycle while
    // go is high, stop at the step budget or when the end stop is reached after bnd_at steps.
    logic [3:0] fwd_st, bwd_st;
    logic       fwd_dn, bwd_dn, bnd_r;
    int         fwd_cnt, bwd_cnt;
    int         bnd_at;
    logic       spur_fwd, spur_bwd;

    assign fwd_state = fwd_st;
    assign bwd_state = bwd_st;
    assign fwd_done  = fwd_dn | spur_fwd;
    assign bwd_done  = bwd_dn | spur_bwd;
    assign boundary  = bnd_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_st <= 4'b1100; bwd_st <= 4'b1100;
            fwd_cnt <= 0; bwd_cnt <= 0;
            fwd_dn <= 1'b0; bwd_dn <= 1'b0; bnd_r <= 1'b0;
        end else begin
            if (!go_fwd) begin
                fwd_cnt <= 0; fwd_dn <= 1'b0; fwd_st <= old_state;
            end else if (!fwd_dn) begin
                fwd_st  <= {fwd_st[2:0], fwd_st[3]};
                fwd_cnt <= fwd_cnt + 1;
                if (fwd_cnt == 0) bnd_r <= 1'b0;
                if (fwd_cnt + 1 == int'(steps) || (bnd_at != 0 && fwd_cnt + 1 == bnd_at)) fwd_dn <= 1'b1;
                if (bnd_at != 0 && fwd_cnt + 1 == bnd_at) bnd_r <= 1'b1;
            end
            if (!go_bwd) begin
                bwd_cnt <= 0; bwd_dn <= 1'b0; bwd_st <= old_state;
            end else if (!bwd_dn) begin
                bwd_st  <= {bwd_st[0], bwd_st[3:1]};
                bwd_cnt <= bwd_cnt + 1;
                if (bwd_cnt == 0) bnd_r <= 1'b0;
                if (bwd_cnt + 1 == int'(steps) || (bnd_at != 0 && bwd_cnt + 1 == bnd_at)) bwd_dn <= 1'b1;
                if (bnd_at != 0 && bwd_cnt + 1 == bnd_at) bnd_r <= 1'b1;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model state: axis position, flags, and the coil pattern the drivers end on.
    int         m_pos;
    bit         m_homed;
    bit         m_err;
    logic [3:0] m_coil;

    function automatic logic [3:0] rot(input logic [3:0] c, input int n, input bit fwd);
        logic [3:0] r;
        r = c;
        for (int k = 0; k < n % 4; k++) r = fwd ? {r[2:0], r[3]} : {r[0], r[3:1]};
        return r;
    endfunction

    task automatic model_next(input bit home, input int target, input int bnd,
                              output int e_steps, output int e_dir, output int e_pos,
                              output bit e_homed, output bit e_err);
        int taken;
        bit hit;
        e_pos = m_pos; e_homed = m_homed; e_err = m_err; e_steps = 0; e_dir = 0;
        if (home) begin
            e_steps = 4095; e_dir = 2;
            hit = (bnd != 0 && bnd <= 4095);
            if (hit) begin
                e_pos = 0; e_homed = 1'b1; e_err = 1'b0;
            end else begin
                e_pos = (m_pos > 4095) ? m_pos - 4095 : 0; e_homed = 1'b0; e_err = 1'b1;
            end
        end else if (target != m_pos) begin
            e_dir   = (target > m_pos) ? 1 : 2;
            e_steps = (target > m_pos) ? target - m_pos : m_pos - target;
            hit     = (bnd != 0 && bnd <= e_steps);
            taken   = hit ? bnd : e_steps;
            e_pos   = (e_dir == 1) ? m_pos + taken : m_pos - taken;
            if (hit) begin
                e_err = 1'b1; e_homed = 1'b0;
            end else if (!m_homed) begin
                e_err = 1'b1;
            end
        end
    endtask

    // e_dir: 0 = no go pulse, 1 = forward, 2 = backward.
    task automatic run_cmd(input string tag, input bit home, input int target, input int bnd,
                           input bit spur, input int e_steps, input int e_dir, input int e_pos,
                           input bit e_homed, input bit e_err);
        int cyc, golow, taken;
        bit overlap;
        check({tag, " ready_before"}, int'(cmd_ready), 1);
        bnd_at     = bnd;
        spur_fwd   = spur && (e_dir == 2);
        spur_bwd   = spur && (e_dir == 1);
        cmd_valid  = 1'b1;
        cmd_home   = home;
        cmd_target = 12'(target);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({tag, " ready_low"}, int'(cmd_ready), 0);
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " go_fwd"}, int'(go_fwd), int'(e_dir == 1));
        check({tag, " go_bwd"}, int'(go_bwd), int'(e_dir == 2));
        if (e_dir != 0) check({tag, " steps"}, int'(steps), e_steps);
        cyc = 0; golow = 0; overlap = 1'b0;
        while (cmd_ready !== 1'b1 && cyc < 6000) begin
            overlap |= go_fwd & go_bwd;
            golow = (go_fwd | go_bwd) ? 0 : golow + 1;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " completes"}, int'(cyc < 6000), 1);
        check({tag, " go_overlap"}, int'(overlap), 0);
        if (e_dir == 0) check({tag, " ready_latency"}, cyc, 1);
        else check({tag, " go_gap"}, int'(golow >= 1), 1);
        check({tag, " go_idle"}, int'(go_fwd | go_bwd), 0);
        check({tag, " position"}, int'(position), e_pos);
        check({tag, " homed"}, int'(homed), int'(e_homed));
        check({tag, " error"}, int'(error), int'(e_err));
        check({tag, " busy_end"}, int'(busy), 0);
        if (e_dir != 0) begin
            taken  = (bnd != 0 && bnd <= e_steps) ? bnd : e_steps;
            m_coil = rot(m_coil, taken, e_dir == 1);
            check({tag, " old_state"}, int'(old_state), int'(m_coil));
        end
        spur_fwd = 1'b0; spur_bwd = 1'b0;
        m_pos = e_pos; m_homed = e_homed; m_err = e_err;
        $display("cmd %s home=%0d target=%0d bnd=%0d -> pos=%0d homed=%0d error=%0d cycles=%0d",
                 tag, home, target, bnd, position, homed, error, cyc);
    endtask

    typedef struct {
        bit home; int target; int bnd; bit spur;
        int e_steps; int e_dir; int e_pos; bit e_homed; bit e_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cyc;
        int r_steps, r_dir, r_pos;
        bit r_homed, r_err, r_home;
        int r_target, r_bnd;

        vecs[0]  = '{1'b1,    0, 37, 1'b0, 4095, 2,    0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0,  100,  0, 1'b1,  100, 1,  100, 1'b1, 1'b0};
        vecs[2]  = '{1'b0,   40,  0, 1'b1,   60, 2,   40, 1'b1, 1'b0};
        vecs[3]  = '{1'b0,   40,  0, 1'b0,    0, 0,   40, 1'b1, 1'b0};
        vecs[4]  = '{1'b0,  500, 10, 1'b0,  460, 1,   50, 1'b0, 1'b1};
        vecs[5]  = '{1'b1,    0, 50, 1'b0, 4095, 2,    0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1,    0,  0, 1'b0, 4095, 2,    0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0,   30,  0, 1'b0,   30, 1,   30, 1'b0, 1'b1};
        vecs[8]  = '{1'b1,    0, 30, 1'b0, 4095, 2,    0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4095,  0, 1'b0, 4095, 1, 4095, 1'b1, 1'b0};
        vecs[10] = '{1'b0,  200,  0, 1'b0, 3895, 2,  200, 1'b1, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_home = 1'b0; cmd_target = '0;
        bnd_at = 0; spur_fwd = 1'b0; spur_bwd = 1'b0;
        m_pos = 0; m_homed = 1'b0; m_err = 1'b0; m_coil = 4'b1100;
        repeat (2) @(posedge clk);
        #1;
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset go", int'({go_fwd, go_bwd}), 0);
        check("reset steps", int'(steps), 0);
        check("reset old_state", int'(old_state), 12);
        check("reset position", int'(position), 0);
        check("reset homed", int'(homed), 0);
        check("reset error", int'(error), 0);
        check("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].home, vecs[i].target, vecs[i].bnd, vecs[i].spur,
                    vecs[i].e_steps, vecs[i].e_dir, vecs[i].e_pos, vecs[i].e_homed, vecs[i].e_err);

        // Reset pulled mid-move, 20 steps into a forward run from 200.
        bnd_at = 0;
        cmd_valid = 1'b1; cmd_home = 1'b0; cmd_target = 12'd300;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (position != 12'd220 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst reached_step20", int'(cyc < 400), 1);
        check("rst go_before", int'(go_fwd), 1);
        rst_n = 1'b0;
        #1;
        check("rst go_fwd", int'(go_fwd), 0);
        check("rst position", int'(position), 0);
        check("rst old_state", int'(old_state), 12);
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst steps", int'(steps), 0);
        check("rst busy", int'(busy), 0);
        check("rst homed", int'(homed), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst ready_after", int'(cmd_ready), 1);
        $display("cmd rst_mid_move -> pos=%0d old_state=%b cmd_ready=%0d", position, old_state, cmd_ready);
        m_pos = 0; m_homed = 1'b0; m_err = 1'b0; m_coil = 4'b1100;

        for (int i = 0; i < 20; i++) begin
            r_home   = (i == 0) || ($urandom_range(0, 5) == 0);
            r_target = $urandom_range(0, 600);
            if (r_home) r_bnd = $urandom_range(1, 300);
            else r_bnd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 400) : 0;
            model_next(r_home, r_target, r_bnd, r_steps, r_dir, r_pos, r_homed, r_err);
            run_cmd($sformatf("rnd%0d", i), r_home, r_target, r_bnd, 1'($urandom_range(0, 1)),
                    r_steps, r_dir, r_pos, r_homed, r_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
